// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared types and constants for the falling-piece datapath.
//   block_t  : 4x4 piece shape, block[row][col], row 0 / col 0 at the top-left
//   map_t    : 9x12 occupancy map, map[row][col]; row 8 is the floor,
//              cols 0-2 and 11 are walls
//   cmd_e    : move request encoding
//   state_e  : piece_mover controller states
//   rotate_cw: clockwise rotation of a 4x4 shape
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam int MAP_ROWS  = 9;
    localparam int MAP_COLS  = 12;
    localparam int FLOOR_ROW = 8;

    typedef logic [0:3][0:3] block_t;
    typedef logic [0:MAP_ROWS-1][0:MAP_COLS-1] map_t;

    typedef enum logic [1:0] {
        CMD_LEFT      = 2'd0,
        CMD_RIGHT     = 2'd1,
        CMD_ROTATE_CW = 2'd2,
        CMD_DOWN      = 2'd3
    } cmd_e;

    // SPAWN loads the new shape; SPAWN_CHECK tests it one cycle later so the
    // collision check sees the pose that is actually on the outputs.
    typedef enum logic [2:0] {
        ST_SPAWN,
        ST_SPAWN_CHECK,
        ST_WAIT,
        ST_CHECK,
        ST_LOCK,
        ST_SETTLE,
        ST_OVER
    } state_e;

    // Clockwise rotation: out[r][c] = b[3-c][r].
    function automatic block_t rotate_cw(input block_t b);
        block_t out;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                out[r][c] = b[3-c][r];
            end
        end
        return out;
    endfunction

endpackage

// File: rtl/piece_collide.sv
// -----------------------------------------------------------------------------
// piece_collide
// Combinational collision test of a candidate piece pose against the map.
// Ports:
//   cand  in  block_t  candidate shape
//   x5    in  5        map column of shape column 0 (5 bits so wrap is visible)
//   y5    in  5        map row of shape row 0
//   map   in  map_t    occupancy map
//   hit   out 1        candidate overlaps a set map cell or leaves the map
// -----------------------------------------------------------------------------
module piece_collide
    import tetris_pkg::*;
(
    input  block_t     cand,
    input  logic [4:0] x5,
    input  logic [4:0] y5,
    input  map_t       map,
    output logic       hit
);

    logic [5:0] row;
    logic [5:0] col;

    // Coordinates are widened to 6 bits before adding the cell offset, so a
    // wrapped x (e.g. 31 after 0-1) always lands beyond the last column.
    always_comb begin
        hit = 1'b0;
        row = '0;
        col = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                row = {1'b0, y5} + 6'(r);
                col = {1'b0, x5} + 6'(c);
                if (cand[r][c]) begin
                    if (row > 6'(FLOOR_ROW) || col > 6'(MAP_COLS - 1)) begin
                        hit = 1'b1;
                    end else if (map[row[3:0]][col[3:0]]) begin
                        hit = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/piece_mover.sv
// -----------------------------------------------------------------------------
// piece_mover
// Owns the live falling piece: applies move/gravity requests after a collision
// test, locks the piece when a down step is blocked, waits for the map to
// settle and spawns the next piece. A blocked spawn ends the game.
// Ports:
//   clk              in   1        clock
//   reset            in   1        asynchronous, active-high
//   cmd_valid        in   1        move request valid
//   cmd              in   2        0=LEFT 1=RIGHT 2=ROTATE_CW 3=DOWN
//   cmd_ready        out  1        request accepted when valid & ready
//   gravity_tick     in   1        one-cycle pulse, treated as a DOWN request
//   next_block       in   block_t  shape loaded at spawn
//   map              in   map_t    occupancy map (walls, floor, locked cells)
//   block            out  block_t  live piece shape
//   cur_x            out  4        map column of block column 0
//   cur_y            out  4        map row of block row 0
//   load_next_block  out  1        one-cycle pulse: lock the live piece now
//   game_over        out  1        sticky until reset
// -----------------------------------------------------------------------------
module piece_mover
    import tetris_pkg::*;
#(
    parameter logic [3:0] SPAWN_X       = 4'd5,
    parameter logic [3:0] SPAWN_Y       = 4'd0,
    parameter int         SETTLE_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       gravity_tick,
    input  block_t     next_block,
    input  map_t       map,
    output block_t     block,
    output logic [3:0] cur_x,
    output logic [3:0] cur_y,
    output logic       load_next_block,
    output logic       game_over
);

    state_e     state;
    state_e     state_next;
    cmd_e       pend_cmd;
    cmd_e       pend_cmd_next;
    logic       grav_pend;
    logic       grav_pend_next;
    logic [3:0] settle_cnt;
    logic [3:0] settle_cnt_next;
    block_t     block_next;
    logic [3:0] cur_x_next;
    logic [3:0] cur_y_next;
    logic       game_over_next;

    block_t     cand_block;
    logic [4:0] cand_x;
    logic [4:0] cand_y;
    logic       underflow;
    logic       collide_hit;
    logic       hit;

    // Candidate pose. Outside CHECK the candidate is the current pose, which
    // is exactly what SPAWN_CHECK needs, so one collider serves both states.
    always_comb begin
        cand_block = block;
        cand_x     = {1'b0, cur_x};
        cand_y     = {1'b0, cur_y};
        underflow  = 1'b0;
        if (state == ST_CHECK) begin
            case (pend_cmd)
                CMD_LEFT: begin
                    cand_x    = {1'b0, cur_x} - 5'd1;
                    underflow = (cur_x == 4'd0);
                end
                CMD_RIGHT:     cand_x     = {1'b0, cur_x} + 5'd1;
                CMD_ROTATE_CW: cand_block = rotate_cw(block);
                CMD_DOWN:      cand_y     = {1'b0, cur_y} + 5'd1;
                default:       cand_block = block;
            endcase
        end
    end

    piece_collide u_collide (
        .cand (cand_block),
        .x5   (cand_x),
        .y5   (cand_y),
        .map  (map),
        .hit  (collide_hit)
    );

    assign hit = collide_hit | underflow;

    // Next-state and output logic. A gravity tick arriving in WAIT is handled
    // in the same cycle as a pending one, so it always wins over a command
    // presented alongside it.
    always_comb begin
        state_next      = state;
        pend_cmd_next   = pend_cmd;
        grav_pend_next  = grav_pend;
        settle_cnt_next = settle_cnt;
        block_next      = block;
        cur_x_next      = cur_x;
        cur_y_next      = cur_y;
        game_over_next  = game_over;
        cmd_ready       = 1'b0;
        load_next_block = 1'b0;

        if (gravity_tick && state != ST_OVER) begin
            grav_pend_next = 1'b1;
        end

        case (state)
            ST_SPAWN: begin
                block_next = next_block;
                cur_x_next = SPAWN_X;
                cur_y_next = SPAWN_Y;
                state_next = ST_SPAWN_CHECK;
            end
            ST_SPAWN_CHECK: begin
                if (hit) begin
                    game_over_next = 1'b1;
                    state_next     = ST_OVER;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (grav_pend || gravity_tick) begin
                    pend_cmd_next  = CMD_DOWN;
                    grav_pend_next = 1'b0;
                    state_next     = ST_CHECK;
                end else begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        pend_cmd_next = cmd_e'(cmd);
                        state_next    = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (!hit) begin
                    block_next = cand_block;
                    cur_x_next = cand_x[3:0];
                    cur_y_next = cand_y[3:0];
                    state_next = ST_WAIT;
                end else if (pend_cmd == CMD_DOWN) begin
                    state_next = ST_LOCK;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_LOCK: begin
                load_next_block = 1'b1;
                settle_cnt_next = 4'(SETTLE_CYCLES - 1);
                state_next      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_next = ST_SPAWN;
                end else begin
                    settle_cnt_next = settle_cnt - 4'd1;
                end
            end
            ST_OVER: begin
                state_next = ST_OVER;
            end
            default: begin
                state_next = ST_SPAWN;
            end
        endcase
    end

    // State register; reset abandons any lock/settle sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_SPAWN;
            pend_cmd   <= CMD_DOWN;
            grav_pend  <= 1'b0;
            settle_cnt <= '0;
            block      <= '0;
            cur_x      <= SPAWN_X;
            cur_y      <= SPAWN_Y;
            game_over  <= 1'b0;
        end else begin
            state      <= state_next;
            pend_cmd   <= pend_cmd_next;
            grav_pend  <= grav_pend_next;
            settle_cnt <= settle_cnt_next;
            block      <= block_next;
            cur_x      <= cur_x_next;
            cur_y      <= cur_y_next;
            game_over  <= game_over_next;
        end
    end

endmodule

// File: tb/tb_piece_mover.sv
// -----------------------------------------------------------------------------
// tb_piece_mover
// Directed bench for piece_mover. The stimulus side pushes the expected pose
// of every visible DUT event (return to ready, lock pulse, game over) into a
// queue; a monitor pops and compares whenever such an event appears. A small
// map-builder model paints locked pieces into the map.
// -----------------------------------------------------------------------------
module tb_piece_mover;
    import tetris_pkg::*;

    localparam logic [1:0] EV_READY = 2'd0;
    localparam logic [1:0] EV_LOCK  = 2'd1;
    localparam logic [1:0] EV_OVER  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [15:0] blk;
        logic        go;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       gravity_tick;
    block_t     next_block;
    map_t       map;
    block_t     block;
    logic [3:0] cur_x;
    logic [3:0] cur_y;
    logic       load_next_block;
    logic       game_over;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_compared   = 0;
    int    n_mismatched = 0;

    logic       ready_q  = 1'b0;
    logic       go_q     = 1'b0;
    logic       load_q   = 1'b0;
    logic       mb_load_q = 1'b0;
    logic       lock_top = 1'b0;
    logic       mon_ev;
    logic [1:0] mon_kind;
    exp_t       mon_exp;
    string      mon_name;

    always #5 clk = ~clk;

    piece_mover dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd             (cmd),
        .cmd_ready       (cmd_ready),
        .gravity_tick    (gravity_tick),
        .next_block      (next_block),
        .map             (map),
        .block           (block),
        .cur_x           (cur_x),
        .cur_y           (cur_y),
        .load_next_block (load_next_block),
        .game_over       (game_over)
    );

    function automatic map_t base_map();
        map_t m;
        for (int r = 0; r < MAP_ROWS; r++) begin
            for (int c = 0; c < MAP_COLS; c++) begin
                m[r][c] = (r == FLOOR_ROW) || (c < 3) || (c == MAP_COLS - 1);
            end
        end
        return m;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_event(input string name, input logic [1:0] kind,
                                input logic [3:0] x, input logic [3:0] y,
                                input logic [15:0] blk, input logic go);
        exp_t e;
        e.kind = kind;
        e.x    = x;
        e.y    = y;
        e.blk  = blk;
        e.go   = go;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL timeout_%s: got %0d pending events, required 0",
                     name_q[0], exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Present a command and hold it until the DUT accepts it.
    task automatic apply_stimulus(input logic [1:0] c, input logic with_tick);
        bit accepted;
        accepted = 1'b0;
        @(posedge clk); #1;
        cmd_valid    = 1'b1;
        cmd          = c;
        gravity_tick = with_tick;
        if (with_tick) begin
            @(posedge clk); #1;
            gravity_tick = 1'b0;
        end
        for (int k = 0; k < 40 && !accepted; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk); #1;
                accepted = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        if (!accepted) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL cmd_accept: got 0, required 1");
        end
        wait_drain(60);
    endtask

    task automatic tick_once();
        @(posedge clk); #1;
        gravity_tick = 1'b1;
        @(posedge clk); #1;
        gravity_tick = 1'b0;
        wait_drain(60);
    endtask

    // Monitor: one scoreboard pop per visible event.
    always @(negedge clk) begin
        if (!reset) begin
            mon_ev   = 1'b0;
            mon_kind = EV_READY;
            if (load_next_block && !load_q) begin
                mon_ev   = 1'b1;
                mon_kind = EV_LOCK;
            end else if (game_over && !go_q) begin
                mon_ev   = 1'b1;
                mon_kind = EV_OVER;
            end else if (cmd_ready && !ready_q) begin
                mon_ev   = 1'b1;
                mon_kind = EV_READY;
            end
            if (mon_ev) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_event: got kind %0d, required none",
                             mon_kind);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    mon_name = name_q.pop_front();
                    check_output({mon_name, "_kind"}, 32'(mon_kind), 32'(mon_exp.kind));
                    check_output({mon_name, "_x"}, 32'(cur_x), 32'(mon_exp.x));
                    check_output({mon_name, "_y"}, 32'(cur_y), 32'(mon_exp.y));
                    check_output({mon_name, "_block"}, 32'(block), 32'(mon_exp.blk));
                    check_output({mon_name, "_game_over"}, 32'(game_over), 32'(mon_exp.go));
                end
            end
        end
        ready_q = cmd_ready;
        go_q    = game_over;
        load_q  = load_next_block;
    end

    // Map builder model: paints the locked piece, optionally blocks the top.
    always @(negedge clk) begin
        if (mb_load_q && !reset) begin
            check_output("lock_pulse_one_cycle", 32'(load_next_block), 32'd0);
        end
        if (load_next_block && !reset) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (block[r][c] && (int'(cur_y) + r) < MAP_ROWS
                        && (int'(cur_x) + c) < MAP_COLS) begin
                        map[int'(cur_y) + r][int'(cur_x) + c] = 1'b1;
                    end
                end
            end
            if (lock_top) begin
                for (int r = 0; r < 2; r++) begin
                    for (int c = 5; c < 9; c++) begin
                        map[r][c] = 1'b1;
                    end
                end
                lock_top = 1'b0;
            end
        end
        mb_load_q = load_next_block;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd          = 2'd0;
        gravity_tick = 1'b0;
        map          = base_map();
        next_block   = block_t'(16'h6600);

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_block", 32'(block), 32'h0);
        check_output("reset_x", 32'(cur_x), 32'd5);
        check_output("reset_y", 32'(cur_y), 32'd0);
        check_output("reset_load", 32'(load_next_block), 32'd0);
        check_output("reset_game_over", 32'(game_over), 32'd0);
        check_output("reset_ready", 32'(cmd_ready), 32'd0);

        // O-piece spawn and walk into the left wall
        expect_event("spawn_o", EV_READY, 4'd5, 4'd0, 16'h6600, 1'b0);
        reset = 1'b0;
        wait_drain(60);
        expect_event("left1", EV_READY, 4'd4, 4'd0, 16'h6600, 1'b0);
        apply_stimulus(CMD_LEFT, 1'b0);
        expect_event("left2", EV_READY, 4'd3, 4'd0, 16'h6600, 1'b0);
        apply_stimulus(CMD_LEFT, 1'b0);
        expect_event("left3", EV_READY, 4'd2, 4'd0, 16'h6600, 1'b0);
        apply_stimulus(CMD_LEFT, 1'b0);
        expect_event("left_wall", EV_READY, 4'd2, 4'd0, 16'h6600, 1'b0);
        apply_stimulus(CMD_LEFT, 1'b0);

        // Gravity down to the floor, lock, respawn vertical I
        for (int i = 1; i <= 6; i++) begin
            expect_event("grav_fall", EV_READY, 4'd2, 4'(i), 16'h6600, 1'b0);
            tick_once();
        end
        next_block = block_t'(16'h4444);
        expect_event("grav_lock", EV_LOCK, 4'd2, 4'd6, 16'h6600, 1'b0);
        expect_event("respawn_i", EV_READY, 4'd5, 4'd0, 16'h4444, 1'b0);
        tick_once();

        // Rotation blocked by the right wall, then legal rotations
        for (int i = 6; i <= 8; i++) begin
            expect_event("right", EV_READY, 4'(i), 4'd0, 16'h4444, 1'b0);
            apply_stimulus(CMD_RIGHT, 1'b0);
        end
        expect_event("rot_wall", EV_READY, 4'd8, 4'd0, 16'h4444, 1'b0);
        apply_stimulus(CMD_ROTATE_CW, 1'b0);
        for (int i = 7; i >= 5; i--) begin
            expect_event("left_back", EV_READY, 4'(i), 4'd0, 16'h4444, 1'b0);
            apply_stimulus(CMD_LEFT, 1'b0);
        end
        expect_event("rot_horiz", EV_READY, 4'd5, 4'd0, 16'h0F00, 1'b0);
        apply_stimulus(CMD_ROTATE_CW, 1'b0);
        expect_event("rot_vert", EV_READY, 4'd5, 4'd0, 16'h2222, 1'b0);
        apply_stimulus(CMD_ROTATE_CW, 1'b0);

        // Gravity and RIGHT in the same cycle: DOWN first, then RIGHT
        expect_event("tick_first", EV_READY, 4'd5, 4'd1, 16'h2222, 1'b0);
        expect_event("right_after", EV_READY, 4'd6, 4'd1, 16'h2222, 1'b0);
        apply_stimulus(CMD_RIGHT, 1'b1);

        // Drop and lock with the top blocked: the spawn collides
        next_block = block_t'(16'h6600);
        lock_top   = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            expect_event("drop", EV_READY, 4'd6, 4'(i), 16'h2222, 1'b0);
            tick_once();
        end
        expect_event("final_lock", EV_LOCK, 4'd6, 4'd4, 16'h2222, 1'b0);
        expect_event("game_over", EV_OVER, 4'd5, 4'd0, 16'h6600, 1'b1);
        tick_once();

        // Everything is ignored once the game is over
        @(posedge clk); #1;
        cmd_valid    = 1'b1;
        cmd          = CMD_LEFT;
        gravity_tick = 1'b1;
        @(posedge clk); #1;
        gravity_tick = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_output("over_sticky", 32'(game_over), 32'd1);
        check_output("over_ready", 32'(cmd_ready), 32'd0);
        check_output("over_x", 32'(cur_x), 32'd5);
        check_output("over_y", 32'(cur_y), 32'd0);
        check_output("over_load", 32'(load_next_block), 32'd0);

        // Reset clears game over and restarts
        reset = 1'b1;
        #2;
        check_output("rst2_game_over", 32'(game_over), 32'd0);
        check_output("rst2_block", 32'(block), 32'h0);
        map        = base_map();
        next_block = block_t'(16'h4444);
        @(posedge clk); #1;
        expect_event("restart", EV_READY, 4'd5, 4'd0, 16'h4444, 1'b0);
        reset = 1'b0;
        wait_drain(60);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
